// File: rtl/plain_letter_histogram_pkg.sv
// plain_letter_histogram_pkg
// Shared types and constants for the ETAOIN SHRDLU letter histogram.
//   alpha_t       : one decoded plain letter (ASCII code)
//   NUM_LETTERS   : number of tracked letters (12)
//   LETTER_TABLE  : tracked letters in report order E,T,A,O,I,N,S,H,R,D,L,U
//   letter_index  : table position of a letter, or NUM_LETTERS when not tracked
//   hist_state_t  : histogram FSM states
package plain_letter_histogram_pkg;

    typedef logic [7:0] alpha_t;

    localparam int unsigned NUM_LETTERS = 12;

    localparam alpha_t LETTER_TABLE [NUM_LETTERS] = '{
        "E", "T", "A", "O", "I", "N", "S", "H", "R", "D", "L", "U"
    };

    typedef enum logic {
        Collect,
        Report
    } hist_state_t;

    function automatic logic [3:0] letter_index(input alpha_t letter);
        logic [3:0] idx;
        idx = 4'(NUM_LETTERS);
        for (int i = 0; i < NUM_LETTERS; i++) begin
            if (letter == LETTER_TABLE[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/plain_letter_histogram.sv
// plain_letter_histogram
// Counts ETAOIN SHRDLU letters per message, then reports the 12-entry histogram.
// Ports:
//   i_clk, i_reset_n            : clock, synchronous active-low reset
//   i_in_valid/o_in_ready       : input handshake
//   i_in_letter, i_in_last      : letter beat, message terminator
//   o_out_valid/i_out_ready     : histogram entry handshake
//   o_out_letter, o_out_count   : current entry letter and its count
//   o_out_last                  : current entry is the final one (U)
//   o_msg_len, o_other_count    : message length and untracked-letter count
module plain_letter_histogram
    import plain_letter_histogram_pkg::*;
#(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned LEN_W = 16
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [7:0]       i_in_letter,
    input  logic             i_in_last,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [7:0]       o_out_letter,
    output logic [CNT_W-1:0] o_out_count,
    output logic             o_out_last,
    output logic [LEN_W-1:0] o_msg_len,
    output logic [CNT_W-1:0] o_other_count
);

    hist_state_t      r_state;
    hist_state_t      w_state_next;
    logic [CNT_W-1:0] r_count [NUM_LETTERS];
    logic [CNT_W-1:0] r_other;
    logic [LEN_W-1:0] r_msg_len;
    logic [3:0]       r_index;

    logic       w_accept;
    logic       w_out_fire;
    logic       w_last_entry;
    logic [3:0] w_letter_idx;

    assign w_accept     = i_in_valid && o_in_ready;
    assign w_out_fire   = o_out_valid && i_out_ready;
    assign w_last_entry = (r_index == 4'(NUM_LETTERS - 1));
    assign w_letter_idx = letter_index(i_in_letter);

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state <= Collect;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            Collect: if (w_accept && i_in_last)       w_state_next = Report;
            Report:  if (w_out_fire && w_last_entry)  w_state_next = Collect;
            default:                                  w_state_next = Collect;
        endcase
    end

    // Outputs; in_ready is gated by reset so nothing is accepted while held in reset
    always_comb begin
        o_in_ready    = i_reset_n && (r_state == Collect);
        o_out_valid   = (r_state == Report);
        o_out_letter  = LETTER_TABLE[r_index];
        o_out_count   = r_count[r_index];
        o_out_last    = (r_state == Report) && w_last_entry;
        o_msg_len     = r_msg_len;
        o_other_count = r_other;
    end

    // Counter array, side counters and report index; all counters saturate
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            for (int i = 0; i < NUM_LETTERS; i++) begin
                r_count[i] <= '0;
            end
            r_other   <= '0;
            r_msg_len <= '0;
            r_index   <= '0;
        end else if (w_accept) begin
            if (w_letter_idx < 4'(NUM_LETTERS)) begin
                if (!(&r_count[w_letter_idx])) begin
                    r_count[w_letter_idx] <= r_count[w_letter_idx] + CNT_W'(1);
                end
            end else if (!(&r_other)) begin
                r_other <= r_other + CNT_W'(1);
            end
            if (!(&r_msg_len)) begin
                r_msg_len <= r_msg_len + LEN_W'(1);
            end
        end else if (w_out_fire) begin
            if (w_last_entry) begin
                // Final entry delivered: clear everything for the next message
                for (int i = 0; i < NUM_LETTERS; i++) begin
                    r_count[i] <= '0;
                end
                r_other   <= '0;
                r_msg_len <= '0;
                r_index   <= '0;
            end else begin
                r_index <= r_index + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_plain_letter_histogram.sv
// tb_plain_letter_histogram
// Self-checking bench: a per-message letter-count model builds the expected 12-entry
// report and a monitor compares every presented entry plus the handshake signals.
module tb_plain_letter_histogram;
    import plain_letter_histogram_pkg::*;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned LEN_W = 16;
    localparam int CMAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       in_letter = 8'h0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [7:0]       out_letter;
    logic [CNT_W-1:0] out_count;
    logic             out_last;
    logic [LEN_W-1:0] msg_len;
    logic [CNT_W-1:0] other_count;

    plain_letter_histogram #(
        .CNT_W(CNT_W),
        .LEN_W(LEN_W)
    ) dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .i_in_letter  (in_letter),
        .i_in_last    (in_last),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_out_letter (out_letter),
        .o_out_count  (out_count),
        .o_out_last   (out_last),
        .o_msg_len    (msg_len),
        .o_other_count(other_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int letter;
        int count;
        bit last;
        int len;
        int other;
        int pos;
    } entry_t;

    string  TBL = "ETAOINSHRDLU";
    entry_t exp_q[$];
    int     acc_cnt[12];
    int     acc_other;
    int     acc_len;
    int     last_counts[12];
    int     last_len;
    int     last_other;
    int     hist_done = 0;
    int     checks = 0;
    int     failures = 0;

    task automatic check_eq(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int find_idx(input int l);
        for (int i = 0; i < 12; i++) begin
            if (int'(TBL[i]) == l) return i;
        end
        return 12;
    endfunction

    // Monitor / model: sampled on the falling edge, away from the active edge
    entry_t mon_e;
    int     mon_idx;
    bit     mon_exp_ready;
    always @(negedge clk) begin
        if (!rst_n) begin
            check_eq("in_ready_in_reset", int'(in_ready), 0);
            exp_q.delete();
            for (int i = 0; i < 12; i++) acc_cnt[i] = 0;
            acc_other = 0;
            acc_len   = 0;
        end else begin
            mon_exp_ready = (exp_q.size() == 0);
            check_eq("in_ready", int'(in_ready), int'(mon_exp_ready));
            check_eq("out_valid", int'(out_valid), int'(!mon_exp_ready));
            if (out_valid && !mon_exp_ready) begin
                mon_e = exp_q[0];
                check_eq("out_letter", int'(out_letter), mon_e.letter);
                check_eq("out_count", int'(out_count), mon_e.count);
                check_eq("out_last", int'(out_last), int'(mon_e.last));
                check_eq("msg_len", int'(msg_len), mon_e.len);
                check_eq("other_count", int'(other_count), mon_e.other);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    last_counts[mon_e.pos] = mon_e.count;
                    last_len   = mon_e.len;
                    last_other = mon_e.other;
                    if (mon_e.last) hist_done++;
                end
            end
            if (in_valid && mon_exp_ready) begin
                mon_idx = find_idx(int'(in_letter));
                if (mon_idx < 12) begin
                    if (acc_cnt[mon_idx] < CMAX) acc_cnt[mon_idx]++;
                end else if (acc_other < CMAX) begin
                    acc_other++;
                end
                acc_len++;
                if (in_last) begin
                    for (int p = 0; p < 12; p++) begin
                        mon_e.letter = int'(TBL[p]);
                        mon_e.count  = acc_cnt[p];
                        mon_e.last   = (p == 11);
                        mon_e.len    = acc_len;
                        mon_e.other  = acc_other;
                        mon_e.pos    = p;
                        exp_q.push_back(mon_e);
                    end
                    for (int i = 0; i < 12; i++) acc_cnt[i] = 0;
                    acc_other = 0;
                    acc_len   = 0;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] l, input bit last, input int gap);
        int n;
        repeat (gap) begin
            in_valid = 1'b0;
            cyc();
        end
        in_valid  = 1'b1;
        in_letter = l;
        in_last   = last;
        n = 0;
        while (!in_ready && n < 200) begin
            cyc();
            n++;
        end
        if (n >= 200) check_eq("in_ready_timeout", int'(in_ready), 1);
        cyc();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_hist(input int target, input bit rnd);
        int n;
        n = 0;
        while (hist_done < target && n < 2000) begin
            out_ready = rnd ? ($urandom_range(0, 9) < 7) : 1'b1;
            cyc();
            n++;
        end
        out_ready = 1'b1;
        check_eq("report_done", hist_done, target);
    endtask

    task automatic check_hist(input string name, input int e[12], input int len, input int oth);
        for (int i = 0; i < 12; i++) check_eq({name, "_cnt"}, last_counts[i], e[i]);
        check_eq({name, "_len"}, last_len, len);
        check_eq({name, "_other"}, last_other, oth);
    endtask

    initial begin
        int exp_cnt[12];
        int target;
        int len;
        logic [7:0] l;

        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int e[12];
        int target;
        int len;
        logic [7:0] l;

        // Reset state
        rst_n = 1'b0;
        repeat (3) cyc();
        check_eq("rst_out_valid", int'(out_valid), 0);
        check_eq("rst_out_letter", int'(out_letter), 69);
        check_eq("rst_out_count", int'(out_count), 0);
        check_eq("rst_out_last", int'(out_last), 0);
        check_eq("rst_in_ready", int'(in_ready), 0);
        rst_n = 1'b1;
        #1;
        check_eq("post_rst_in_ready", int'(in_ready), 1);
        cyc();

        // E,T,A
        out_ready = 1'b1;
        send("E", 0, 0);
        send("T", 0, 0);
        send("A", 1, 0);
        wait_hist(1, 0);
        e = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        check_hist("eta", e, 3, 0);

        // S,H,R,D,L,U,Z,U
        send("S", 0, 0);
        send("H", 0, 1);
        send("R", 0, 0);
        send("D", 0, 2);
        send("L", 0, 0);
        send("U", 0, 0);
        send("Z", 0, 1);
        send("U", 1, 0);
        wait_hist(2, 1);
        e = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 2};
        check_hist("shrdlu", e, 8, 1);

        // Saturation: 20 E then LAST E
        repeat (20) send("E", 0, 0);
        send("E", 1, 0);
        wait_hist(3, 0);
        e = '{15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        check_hist("sat", e, 21, 0);

        // Backpressure at index 3
        out_ready = 1'b1;
        send("O", 0, 0);
        send("O", 0, 0);
        send("T", 1, 0);
        repeat (3) cyc();
        out_ready = 1'b0;
        repeat (5) begin
            check_eq("stall_letter", int'(out_letter), 79);
            check_eq("stall_count", int'(out_count), 2);
            cyc();
        end
        wait_hist(4, 0);
        e = '{0, 1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0};
        check_hist("bp", e, 3, 0);

        // IN_VALID held during REPORT, then N LAST
        out_ready = 1'b1;
        send("H", 0, 0);
        in_valid  = 1'b1;
        in_letter = "E";
        in_last   = 1'b1;
        cyc();
        in_letter = "N";
        target = 0;
        while (hist_done < 5 && target < 200) begin
            cyc();
            target++;
        end
        check_eq("hold_first_done", hist_done, 5);
        e = '{1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
        check_hist("hold1", e, 2, 0);
        target = 0;
        while (!in_ready && target < 200) begin
            cyc();
            target++;
        end
        cyc();
        in_valid = 1'b0;
        in_last  = 1'b0;
        wait_hist(6, 0);
        e = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        check_hist("hold2", e, 1, 0);

        // Reset at index 6 of REPORT
        out_ready = 1'b1;
        send("R", 0, 0);
        send("D", 1, 0);
        repeat (6) cyc();
        check_eq("idx6_letter", int'(out_letter), 83);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        #1;
        check_eq("abort_out_valid", int'(out_valid), 0);
        check_eq("abort_in_ready", int'(in_ready), 1);
        check_eq("abort_no_hist", hist_done, 6);
        cyc();
        send("I", 1, 0);
        wait_hist(7, 0);
        e = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        check_hist("after_rst", e, 1, 0);

        // Randomized messages with random gaps and output backpressure
        target = 7;
        for (int m = 0; m < 30; m++) begin
            len = $urandom_range(1, 24);
            for (int b = 0; b < len; b++) begin
                if ($urandom_range(0, 3) != 0) l = 8'(TBL[$urandom_range(0, 11)]);
                else l = 8'($urandom_range(0, 255));
                send(l, (b == len - 1), $urandom_range(0, 2));
            end
            target++;
            wait_hist(target, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
